// File: rtl/fsm_pkg.sv
// Shared constants and types for the programmable Moore sequencer.
package fsm_pkg;

  localparam int FSM_SW_DEF = 3;
  localparam int FSM_IW_DEF = 2;
  localparam int FSM_OW_DEF = 3;
  localparam int FSM_CNT_W  = 16;

  // How the next state is chosen on a given edge.
  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_RESTART = 2'd1,
    STEP_TABLE   = 2'd2,
    STEP_TRAP    = 2'd3
  } step_e;

  function automatic int tbl_depth(input int sw, input int iw);
    return 1 << (sw + iw);
  endfunction

endpackage

// File: rtl/fsm_tbl.sv
// Transition storage: next-state entries plus valid bits, indexed by {state, inputs}.
// Async-cleared synchronous write port, combinational read port.
module fsm_tbl
  import fsm_pkg::*;
#(
  parameter int SW = FSM_SW_DEF,
  parameter int IW = FSM_IW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [SW+IW-1:0] wr_idx_i,
  input  logic [SW-1:0]    wr_next_i,
  input  logic [SW+IW-1:0] rd_idx_i,
  output logic [SW-1:0]    rd_next_o,
  output logic             rd_valid_o
);

  localparam int DEPTH = tbl_depth(SW, IW);

  logic [SW-1:0]    next_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        next_q[i] <= '0;
      end
    end else if (we_i) begin
      next_q[wr_idx_i]  <= wr_next_i;
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Reads see pre-edge contents, so a same-cycle write only affects later steps.
  assign rd_next_o  = next_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/prog_moore_fsm.sv
// Table-driven Moore sequencer loaded by firmware; unprogrammed transitions trap to ERR_STATE.
// Optional transition counter on trans_cnt when FSM_TRANS_CNT_EN is defined.
module prog_moore_fsm
  import fsm_pkg::*;
#(
  parameter int SW        = FSM_SW_DEF,
  parameter int IW        = FSM_IW_DEF,
  parameter int OW        = FSM_OW_DEF,
  parameter int RST_STATE = 0,
  parameter int ERR_STATE = (1 << SW) - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 restart,
  input  logic [IW-1:0]        in_vec,
  input  logic                 cfg_we_tr,
  input  logic                 cfg_we_out,
  input  logic [SW-1:0]        cfg_state,
  input  logic [IW-1:0]        cfg_in,
  input  logic [SW-1:0]        cfg_next,
  input  logic [OW-1:0]        cfg_out,
  output logic [SW-1:0]        state,
  output logic [OW-1:0]        z,
`ifdef FSM_TRANS_CNT_EN
  output logic [FSM_CNT_W-1:0] trans_cnt,
`endif
  output logic                 err
);

  localparam logic [SW-1:0] RST_S = SW'(RST_STATE);
  localparam logic [SW-1:0] ERR_S = SW'(ERR_STATE);
  localparam int            NST   = 1 << SW;

  logic [SW-1:0] state_q, state_d;
  logic [OW-1:0] z_q;
  logic          err_q, err_d;
  step_e         step;

  logic [SW-1:0] tbl_next;
  logic          tbl_valid;

  logic [OW-1:0] out_tbl_q [NST];

  fsm_tbl #(
    .SW (SW),
    .IW (IW)
  ) u_tbl (
    .clk        (clk),
    .rst        (rst),
    .we_i       (cfg_we_tr),
    .wr_idx_i   ({cfg_state, cfg_in}),
    .wr_next_i  (cfg_next),
    .rd_idx_i   ({state_q, in_vec}),
    .rd_next_o  (tbl_next),
    .rd_valid_o (tbl_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NST; i++) begin
        out_tbl_q[i] <= '0;
      end
    end else if (cfg_we_out) begin
      out_tbl_q[cfg_state] <= cfg_out;
    end
  end

  always_comb begin
    step = STEP_HOLD;
    if (restart) begin
      step = STEP_RESTART;
    end else if (en) begin
      step = tbl_valid ? STEP_TABLE : STEP_TRAP;
    end
  end

  always_comb begin
    state_d = state_q;
    case (step)
      STEP_RESTART: state_d = RST_S;
      STEP_TABLE:   state_d = tbl_next;
      STEP_TRAP:    state_d = ERR_S;
      default:      state_d = state_q;
    endcase
  end

  // Entering ERR_STATE by any route (trap or a programmed edge) raises err.
  always_comb begin
    err_d = err_q | (state_d == ERR_S);
    if (step == STEP_RESTART) begin
      err_d = 1'b0;
    end
  end

`ifdef FSM_TRANS_CNT_EN
  logic [FSM_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step == STEP_RESTART) begin
      cnt_d = '0;
    end else if ((state_d != state_q) && (cnt_q != {FSM_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign trans_cnt = cnt_q;
`endif

  // z is reloaded every edge from the pre-edge output table at the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_S;
      z_q     <= '0;
      err_q   <= 1'b0;
`ifdef FSM_TRANS_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      z_q     <= out_tbl_q[state_d];
      err_q   <= err_d;
`ifdef FSM_TRANS_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign state = state_q;
  assign z     = z_q;
  assign err   = err_q;

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Self-checking bench for prog_moore_fsm against a behavioural table model.
module tb_prog_moore_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, restart = 1'b0;
  logic [1:0] in_vec = '0;
  logic       cfg_we_tr = 1'b0, cfg_we_out = 1'b0;
  logic [2:0] cfg_state = '0;
  logic [1:0] cfg_in = '0;
  logic [2:0] cfg_next = '0;
  logic [2:0] cfg_out = '0;
  logic [2:0] state;
  logic [2:0] z;
  logic       err;
`ifdef FSM_TRANS_CNT_EN
  logic [15:0] trans_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: plain arrays holding what firmware has written.
  int m_next [32];
  bit m_valid [32];
  int m_out [8];
  int m_state, m_z, m_err, m_cnt;

  logic [5:0] exp_q [$];

  prog_moore_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .restart    (restart),
    .in_vec     (in_vec),
    .cfg_we_tr  (cfg_we_tr),
    .cfg_we_out (cfg_we_out),
    .cfg_state  (cfg_state),
    .cfg_in     (cfg_in),
    .cfg_next   (cfg_next),
    .cfg_out    (cfg_out),
    .state      (state),
    .z          (z),
`ifdef FSM_TRANS_CNT_EN
    .trans_cnt  (trans_cnt),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) begin
      m_next[i] = 0;
      m_valid[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) m_out[i] = 0;
    m_state = 0; m_z = 0; m_err = 0; m_cnt = 0;
  endtask

  // One clock edge: model computes from pre-edge tables, then applies writes.
  task automatic tick();
    int idx, ns, nz, ne, nc;
    idx = m_state * 4 + int'(in_vec);
    if (restart) ns = 0;
    else if (en) ns = m_valid[idx] ? m_next[idx] : 7;
    else ns = m_state;
    nz = m_out[ns];
    ne = restart ? 0 : ((ns == 7) ? 1 : m_err);
    nc = restart ? 0 : ((ns != m_state && m_cnt < 65535) ? m_cnt + 1 : m_cnt);
    if (cfg_we_tr) begin
      m_next[int'(cfg_state) * 4 + int'(cfg_in)] = int'(cfg_next);
      m_valid[int'(cfg_state) * 4 + int'(cfg_in)] = 1'b1;
    end
    if (cfg_we_out) m_out[cfg_state] = int'(cfg_out);
    @(posedge clk);
    m_state = ns; m_z = nz; m_err = ne; m_cnt = nc;
    #1;
  endtask

  task automatic idle();
    en = 1'b0; restart = 1'b0; in_vec = '0;
    cfg_we_tr = 1'b0; cfg_we_out = 1'b0;
  endtask

  task automatic wr_tr(input int s, input int i, input int n);
    idle();
    cfg_we_tr = 1'b1; cfg_state = 3'(s); cfg_in = 2'(i); cfg_next = 3'(n);
    tick();
    idle();
  endtask

  task automatic wr_out(input int s, input int o);
    idle();
    cfg_we_out = 1'b1; cfg_state = 3'(s); cfg_out = 3'(o);
    tick();
    idle();
  endtask

  task automatic do_restart();
    idle();
    restart = 1'b1;
    tick();
    idle();
  endtask

  task automatic step(input int iv);
    idle();
    en = 1'b1; in_vec = 2'(iv);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({state, z, err} !== 7'b000_000_0) begin
      n_errors++;
      $display("FAIL reset: got state=%0d z=%0d err=%0d, want 0 0 0", state, z, err);
    end
`ifdef FSM_TRANS_CNT_EN
    n_checks++;
    if (trans_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %0d, want 0", trans_cnt);
    end
`endif
    rst = 1'b0;
    #2;
  endtask

  task automatic test_unprogrammed();
    for (int k = 0; k < 2; k++) begin
      step(0);
      n_checks++;
      if ({state, z, err} !== {3'd7, 3'd0, 1'b1}) begin
        n_errors++;
        $display("FAIL unprog_%0d: got state=%0d z=%0d err=%0d, want 7 0 1", k, state, z, err);
      end
    end
  endtask

  task automatic test_baseline();
    logic [5:0] e;
    do_restart();
    wr_tr(0, 2, 5); wr_tr(5, 0, 2); wr_tr(2, 0, 3); wr_tr(3, 0, 1); wr_tr(1, 0, 1);
    wr_out(1, 5); wr_out(2, 1); wr_out(3, 2); wr_out(5, 0);
    exp_q.push_back({3'd5, 3'd0}); exp_q.push_back({3'd2, 3'd1});
    exp_q.push_back({3'd3, 3'd2}); exp_q.push_back({3'd1, 3'd5});
    exp_q.push_back({3'd1, 3'd5});
    for (int k = 0; k < 5; k++) begin
      step((k == 0) ? 2 : 0);
      e = exp_q.pop_front();
      n_checks++;
      if ({state, z} !== e || {state, z} !== {3'(m_state), 3'(m_z)}) begin
        n_errors++;
        $display("FAIL baseline_%0d: got state=%0d z=%0d, want state=%0d z=%0d", k, state, z, e[5:3], e[2:0]);
      end
    end
  endtask

  task automatic test_collision();
    do_restart();
    idle();
    en = 1'b1; in_vec = 2'b10;
    cfg_we_tr = 1'b1; cfg_state = 3'd0; cfg_in = 2'b10; cfg_next = 3'd4;
    tick();
    idle();
    n_checks++;
    if (state !== 3'd5) begin
      n_errors++;
      $display("FAIL collision_old: got state=%0d, want 5", state);
    end
    do_restart();
    step(2);
    n_checks++;
    if ({state, z, err} !== {3'd4, 3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL collision_new: got state=%0d z=%0d err=%0d, want 4 0 0", state, z, err);
    end
  endtask

  task automatic test_restart_err();
    wr_out(0, 6);
    step(0);
    n_checks++;
    if ({state, err} !== {3'd7, 1'b1}) begin
      n_errors++;
      $display("FAIL enter_err: got state=%0d err=%0d, want 7 1", state, err);
    end
    // Restart while an invalid step is also requested: restart wins.
    idle();
    restart = 1'b1; en = 1'b1;
    tick();
    idle();
    n_checks++;
    if ({state, z, err} !== {3'd0, 3'd6, 1'b0}) begin
      n_errors++;
      $display("FAIL restart_err: got state=%0d z=%0d err=%0d, want 0 6 0", state, z, err);
    end
`ifdef FSM_TRANS_CNT_EN
    n_checks++;
    if (trans_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL restart_cnt: got %0d, want 0", trans_cnt);
    end
`endif
  endtask

  task automatic test_z_write_timing();
    wr_out(0, 3);
    n_checks++;
    if (z !== 3'd6) begin
      n_errors++;
      $display("FAIL z_old: got z=%0d, want 6", z);
    end
    idle();
    tick();
    n_checks++;
    if (z !== 3'd3) begin
      n_errors++;
      $display("FAIL z_new: got z=%0d, want 3", z);
    end
    // Both tables written in the same cycle.
    idle();
    cfg_we_tr = 1'b1; cfg_we_out = 1'b1;
    cfg_state = 3'd6; cfg_in = 2'd1; cfg_next = 3'd0; cfg_out = 3'd4;
    tick();
    idle();
    wr_tr(0, 1, 6);
    step(1);
    n_checks++;
    if ({state, z} !== {3'd6, 3'd4}) begin
      n_errors++;
      $display("FAIL dual_write: got state=%0d z=%0d, want 6 4", state, z);
    end
    step(1);
    n_checks++;
    if ({state, z} !== {3'd0, 3'd3}) begin
      n_errors++;
      $display("FAIL dual_write_back: got state=%0d z=%0d, want 0 3", state, z);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      en = 1'($urandom_range(0, 1));
      restart = ($urandom_range(0, 15) == 0);
      in_vec = 2'($urandom_range(0, 3));
      cfg_we_tr = ($urandom_range(0, 3) == 0);
      cfg_we_out = ($urandom_range(0, 3) == 0);
      cfg_state = 3'($urandom_range(0, 7));
      cfg_in = 2'($urandom_range(0, 3));
      cfg_next = 3'($urandom_range(0, 7));
      cfg_out = 3'($urandom_range(0, 7));
      tick();
      n_checks++;
      if ({state, z, err} !== {3'(m_state), 3'(m_z), 1'(m_err)}) begin
        n_errors++;
        if (bad < 5)
          $display("FAIL random_%0d: got state=%0d z=%0d err=%0d, want %0d %0d %0d",
                   k, state, z, err, m_state, m_z, m_err);
        bad++;
      end
`ifdef FSM_TRANS_CNT_EN
      n_checks++;
      if (trans_cnt !== 16'(m_cnt)) begin
        n_errors++;
        if (bad < 5) $display("FAIL random_cnt_%0d: got %0d, want %0d", k, trans_cnt, m_cnt);
        bad++;
      end
`endif
    end
    idle();
  endtask

  task automatic test_async_rst();
    do_restart();
    wr_tr(0, 0, 3);
    step(0);
    n_checks++;
    if (state !== 3'd3) begin
      n_errors++;
      $display("FAIL async_pre: got state=%0d, want 3", state);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({state, z, err} !== 7'b000_000_0) begin
      n_errors++;
      $display("FAIL async_rst: got state=%0d z=%0d err=%0d, want 0 0 0", state, z, err);
    end
    mdl_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(i);
      n_checks++;
      if ({state, err} !== {3'd7, 1'b1}) begin
        n_errors++;
        $display("FAIL post_rst_invalid_%0d: got state=%0d err=%0d, want 7 1", i, state, err);
      end
      do_restart();
    end
  endtask

`ifdef FSM_TRANS_CNT_EN
  task automatic test_trans_cnt();
    do_restart();
    wr_tr(0, 0, 1); wr_tr(1, 0, 0);
    do_restart();
    idle();
    repeat (3) begin
      en = 1'b1; tick();
    end
    idle();
    n_checks++;
    if (trans_cnt !== 16'd3) begin
      n_errors++;
      $display("FAIL cnt_three: got %0d, want 3", trans_cnt);
    end
    repeat (5) tick();
    n_checks++;
    if (trans_cnt !== 16'd3) begin
      n_errors++;
      $display("FAIL cnt_hold: got %0d, want 3", trans_cnt);
    end
    en = 1'b1;
    repeat (70000) tick();
    idle();
    n_checks++;
    if (trans_cnt !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL cnt_sat: got %0h, want ffff", trans_cnt);
    end
    do_restart();
    n_checks++;
    if (trans_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL cnt_restart: got %0d, want 0", trans_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unprogrammed();
    test_baseline();
    test_collision();
    test_restart_err();
    test_z_write_timing();
    test_random();
    test_async_rst();
`ifdef FSM_TRANS_CNT_EN
    test_trans_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_moore_fsm.md
# prog_moore_fsm

Table-driven, parametrised Moore state machine. It generalises the team's hard-coded two-input controllers: transitions and outputs are loaded at run time through a configuration port instead of being fixed in RTL. Unprogrammed transitions are trapped into a dedicated error state and flagged. It sits beside the datapath as a reusable sequencer whose behaviour is loaded by firmware after reset.

## Interface
- SW, 3: state register width; 2^SW states.
- IW, 2: input vector width.
- OW, 3: Moore output width.
- RST_STATE, 0: state entered on rst and on restart.
- ERR_STATE, 2^SW-1: trap state for unprogrammed transitions; must differ from RST_STATE.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high. Clock is clk.
- en  in  1  step enable; the state advances only when this is high.
- restart  in  1  synchronous return to RST_STATE; has priority over en.
- in_vec  in  IW  machine inputs, sampled at the clk edge.
- cfg_we_tr  in  1  write one transition entry.
- cfg_we_out  in  1  write one output entry.
- cfg_state  in  SW  entry state index.
- cfg_in  in  IW  input index; used by transition writes only.
- cfg_next  in  SW  next-state value for a transition write.
- cfg_out  in  OW  output value for an output write.
- state  out  SW  current state.
- z  out  OW  registered Moore output.
- err  out  1  sticky error flag.
- trans_cnt  out  16  transition count; present only when FSM_TRANS_CNT_EN is defined.

## Operation
- Transition table: 2^(SW+IW) entries, each with a valid bit. The entry index is {state, in_vec}.
- Output table: 2^SW entries of OW bits.
- Reset behaviour: rst clears every valid bit and every output entry to 0. After rst, state = RST_STATE, z = 0, err = 0, trans_cnt = 0.
- Next-state selection:
  - restart = 1: next state is RST_STATE.
  - restart = 0 and en = 1, entry valid: next state is the table entry.
  - restart = 0 and en = 1, entry invalid: next state is ERR_STATE.
  - Otherwise the state holds.
- ERR_STATE behaves like any other state. It is absorbing unless firmware programs transitions out of it.
- err:
  - Set on any clock edge where the state moves into ERR_STATE for any reason.
  - Cleared by restart or rst.
  - If restart and an error entry coincide, restart wins: err is cleared and the state goes to RST_STATE.
- Configuration writes:
  - cfg_we_tr writes next = cfg_next at {cfg_state, cfg_in} and sets that entry's valid bit.
  - cfg_we_out writes out_tbl[cfg_state] = cfg_out.
  - Both write enables may be active in the same cycle; they target independent tables.
- Write/step collision: lookups always use the table contents from before the clock edge. A write takes effect for steps on the following cycle.
- cfg_next out of range (only possible when 2^SW states are not all used) is accepted as-is. There is no range check.

## Timing
- Step latency: in_vec sampled at edge N gives the new state and the matching z both visible after edge N. z is registered from out_tbl[next state].
- z is reloaded every cycle, including hold cycles. A write to the output entry of the current state therefore appears on z after the edge following the write cycle (one cycle of old value).
- restart: state = RST_STATE and z = out_tbl[RST_STATE] after the next edge.
- rst mid-operation: all state, table and flag registers clear immediately, without waiting for a clock edge.

## Configuration
- FSM_TRANS_CNT_EN defined:
  - trans_cnt is a 16-bit counter, incremented on each edge where the state value changes.
  - It saturates at 0xFFFF.
  - It is cleared by restart or rst.
- FSM_TRANS_CNT_EN not defined: the trans_cnt port and counter are absent and all other behaviour is identical.

## Structure
- Shared package fsm_pkg holds:
  - default constants FSM_SW_DEF = 3, FSM_IW_DEF = 2, FSM_OW_DEF = 3;
  - the trans_cnt width constant FSM_CNT_W = 16.
- One sub-module, fsm_tbl, holds the transition storage plus valid bits. It has an async-clear synchronous write port and a combinational read port. The output table and the state logic stay in the top level.

## Test plan
- Reset, then step with no programming:
  - with en = 1 and in_vec = 2'b00, after 1 edge state = 7 (ERR_STATE), err = 1, z = 0;
  - holding en = 1 keeps state = 7.
- Program the baseline controller and step it:
  - transitions: 0→5 on in=2'b10 ({y,x}), 5→2, 2→3 on in=2'b00, 3→1, 1→1; output table z[1]=5, z[2]=1, z[3]=2, z[5]=0;
  - drive 10, 00, 00, 00, 00 → states 5, 2, 3, 1, 1 with z = 0, 1, 2, 5, 5.
- Collision:
  - in the same cycle, step from 0 and rewrite entry {0, 2'b10} to 4 → state = 5 (old entry);
  - the next step from 0 goes to 4.
- Restart while in ERR_STATE with err = 1 → next edge gives state = 0, err = 0, z = out_tbl[0]; trans_cnt = 0 when FSM_TRANS_CNT_EN is defined.
- Assert rst asynchronously between edges while in state 3 → state = 0, z = 0 immediately; all transitions invalid afterwards.
- With FSM_TRANS_CNT_EN defined: a 2-state toggle machine stepped 70000 cycles → trans_cnt = 0xFFFF; hold cycles do not increment it.
